fir_coeff_ctrl: RTL

//   Configuration and sequencing controller for the 8-tap FIR datapath.
//   - Host loads new coefficients into a shadow bank over a valid/ready write port.
//   - On commit, the shadow bank is copied atomically into the active bank that

---
 rtl/fir_pkg.sv | 19 +
 rtl/fir_coeff_bank.sv | 38 +++
 rtl/fir_coeff_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared constants, state encoding and bus-slice helper for the FIR coefficient controller.
package fir_pkg;
    localparam int          N1        = 8;
    localparam int          CW        = 8;
    localparam int          AW        = 3;
    localparam int          FW        = 4;
    localparam logic [7:0]  DEF_COEFF = 8'h10;
    localparam logic [7:0]  MAX_WAIT  = 8'd255;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    typedef logic [CW-1:0] coeff_t;
    typedef logic [FW-1:0] fill_t;
endpackage

`define FIR_TAP(bus, k) bus[(k)*fir_pkg::CW +: fir_pkg::CW]

// File: rtl/fir_coeff_bank.sv
// Shadow and active coefficient register banks; the swap moves all taps on one edge.
module fir_coeff_bank
    import fir_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [CW-1:0]     i_wr_data,
    input  logic              i_swap,
    output logic [N1*CW-1:0]  o_coeff_bus
);
    coeff_t r_shadow [N1];
    coeff_t r_active [N1];

    // Shadow bank takes host writes; active bank only changes on a swap.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int k = 0; k < N1; k++) begin
                r_shadow[k] <= DEF_COEFF;
                r_active[k] <= DEF_COEFF;
            end
        end else begin
            if (i_wr_en) begin
                r_shadow[i_wr_addr] <= i_wr_data;
            end
            if (i_swap) begin
                for (int k = 0; k < N1; k++) begin
                    r_active[k] <= r_shadow[k];
                end
            end
        end
    end

    for (genvar k = 0; k < N1; k++) begin : g_tap
        assign `FIR_TAP(o_coeff_bus, k) = r_active[k];
    end
endmodule

// File: rtl/fir_coeff_ctrl.sv
// FIR coefficient controller: commit FSM, forced-swap timeout, sample enable and fill tracking.
module fir_coeff_ctrl
    import fir_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              SAMPLE_STB,
    output logic              ENABLE,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [AW-1:0]     wr_addr,
    input  logic [CW-1:0]     wr_data,
    input  logic              commit_req,
    output logic              commit_busy,
    output logic [N1*CW-1:0]  coeff_bus,
    output logic              out_valid,
    output logic              swap_forced
);
    state_t     r_state;
    logic [7:0] r_wait_cnt;
    fill_t      r_fill_cnt;
    logic       r_enable;
    logic       r_out_valid;
    logic       r_swap_forced;

    state_t     w_state_nxt;
    logic [7:0] w_wait_nxt;
    fill_t      w_fill_nxt;
    logic       w_swap;
    logic       w_force;
    logic       w_wr_en;

    assign w_wr_en     = wr_valid & (r_state == IDLE);
    assign wr_ready    = (r_state == IDLE);
    assign commit_busy = (r_state == PEND);
    assign ENABLE      = r_enable;
    assign out_valid   = r_out_valid;
    assign swap_forced = r_swap_forced;

    // Commit sequencing: wait for a quiet cycle (no strobe, no enable) or time out.
    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        w_swap      = 1'b0;
        w_force     = 1'b0;
        case (r_state)
            IDLE: begin
                if (commit_req) begin
                    w_state_nxt = PEND;
                    w_wait_nxt  = 8'd0;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            PEND: begin
                if (!SAMPLE_STB && !r_enable) begin
                    w_swap      = 1'b1;
                    w_state_nxt = IDLE;
                end else if (r_wait_cnt == MAX_WAIT) begin
                    w_swap      = 1'b1;
                    w_force     = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_wait_nxt  = r_wait_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_wait_nxt  = 8'd0;
            end
        endcase
    end

    // Delay-line fill count saturates at the tap count; swaps leave it alone.
    always_comb begin
        if (r_enable && (r_fill_cnt != FW'(N1))) begin
            w_fill_nxt = r_fill_cnt + 4'd1;
        end else begin
            w_fill_nxt = r_fill_cnt;
        end
    end

    // State, counters and registered status outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state       <= IDLE;
            r_wait_cnt    <= 8'd0;
            r_fill_cnt    <= 4'd0;
            r_enable      <= 1'b0;
            r_out_valid   <= 1'b0;
            r_swap_forced <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_wait_cnt    <= w_wait_nxt;
            r_fill_cnt    <= w_fill_nxt;
            r_enable      <= SAMPLE_STB;
            r_out_valid   <= (w_fill_nxt == FW'(N1));
            r_swap_forced <= r_swap_forced | w_force;
        end
    end

    fir_coeff_bank u_bank (
        .CLK         (CLK),
        .RST         (RST),
        .i_wr_en     (w_wr_en),
        .i_wr_addr   (wr_addr),
        .i_wr_data   (wr_data),
        .i_swap      (w_swap),
        .o_coeff_bus (coeff_bus)
    );
endmodule
